// File: rtl/l1_mem_scheduler_if.sv
// Bus bundle for l1_mem_scheduler: two cache-side requesters plus the shared memory port.
// slave is the scheduler's view; master is the surrounding environment's view.
interface l1_mem_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned TAG_WIDTH  = 8
) ();
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [1:0]              in_req_valid;
    logic [1:0]              in_req_rw;
    logic [2*ADDR_WIDTH-1:0] in_req_addr;
    logic [2*DATA_WIDTH-1:0] in_req_data;
    logic [2*BE_WIDTH-1:0]   in_req_byteen;
    logic [2*TAG_WIDTH-1:0]  in_req_tag;
    logic [1:0]              in_req_ready;

    logic [1:0]              in_rsp_valid;
    logic [DATA_WIDTH-1:0]   in_rsp_data;
    logic [TAG_WIDTH-1:0]    in_rsp_tag;
    logic [1:0]              in_rsp_ready;

    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_data;
    logic [BE_WIDTH-1:0]     mem_req_byteen;
    logic [TAG_WIDTH:0]      mem_req_tag;
    logic                    mem_req_ready;

    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH:0]      mem_rsp_tag;
    logic                    mem_rsp_ready;

    modport slave (
        input  in_req_valid, in_req_rw, in_req_addr, in_req_data, in_req_byteen, in_req_tag,
        output in_req_ready,
        output in_rsp_valid, in_rsp_data, in_rsp_tag,
        input  in_rsp_ready,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport master (
        output in_req_valid, in_req_rw, in_req_addr, in_req_data, in_req_byteen, in_req_tag,
        input  in_req_ready,
        input  in_rsp_valid, in_rsp_data, in_rsp_tag,
        output in_rsp_ready,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/l1_mem_scheduler.sv
// Two-source L1 memory port scheduler: fixed priority for the I-cache path with a
// bounded-starvation override for the D-cache path, source-tagged requests and response routing.
module l1_mem_scheduler #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_PENDING  = 16
) (
    input  logic                clk,
    input  logic                reset,
    l1_mem_scheduler_if.slave   bus,
    output logic                busy,
    output logic                rsp_err
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PW       = $clog2(MAX_PENDING + 1);
    localparam int unsigned SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                  r_mem_req_valid;
    logic                  r_mem_req_rw;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;
    logic [DATA_WIDTH-1:0] r_mem_req_data;
    logic [BE_WIDTH-1:0]   r_mem_req_byteen;
    logic [TAG_WIDTH:0]    r_mem_req_tag;
    logic [SW-1:0]         r_starve_cnt;
    logic [PW-1:0]         r_pend [2];
    logic                  r_rsp_err;

    logic                  w_slot_free;
    logic [1:0]            w_elig;
    logic                  w_grant_vld;
    logic                  w_grant_src;
    logic [1:0]            w_grant_oh;
    logic                  w_sel_rw;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [BE_WIDTH-1:0]   w_sel_byteen;
    logic [TAG_WIDTH-1:0]  w_sel_tag;
    logic                  w_rsp_src;
    logic                  w_rsp_hs;
    logic [1:0]            w_inc;
    logic [1:0]            w_dec;

    assign w_slot_free = !r_mem_req_valid || bus.mem_req_ready;

    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_elig[i] = bus.in_req_valid[i] && (bus.in_req_rw[i] || (r_pend[i] < PEND_MAX));
        end
    end

    // Grant is suppressed while reset is held so ready never shows during reset.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = 1'b0;
        if (reset && w_slot_free) begin
            if (w_elig[1] && (r_starve_cnt == STARVE_MAX)) begin
                w_grant_vld = 1'b1;
                w_grant_src = 1'b1;
            end else if (w_elig[0]) begin
                w_grant_vld = 1'b1;
                w_grant_src = 1'b0;
            end else if (w_elig[1]) begin
                w_grant_vld = 1'b1;
                w_grant_src = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        if (w_grant_vld) begin
            w_grant_oh = w_grant_src ? 2'b10 : 2'b01;
        end
    end

    assign bus.in_req_ready = w_grant_oh;

    always_comb begin
        w_sel_rw     = w_grant_src ? bus.in_req_rw[1] : bus.in_req_rw[0];
        w_sel_addr   = w_grant_src ? bus.in_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : bus.in_req_addr[ADDR_WIDTH-1:0];
        w_sel_data   = w_grant_src ? bus.in_req_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : bus.in_req_data[DATA_WIDTH-1:0];
        w_sel_byteen = w_grant_src ? bus.in_req_byteen[2*BE_WIDTH-1:BE_WIDTH]
                                   : bus.in_req_byteen[BE_WIDTH-1:0];
        w_sel_tag    = w_grant_src ? bus.in_req_tag[2*TAG_WIDTH-1:TAG_WIDTH]
                                   : bus.in_req_tag[TAG_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req_valid  <= 1'b0;
            r_mem_req_rw     <= 1'b0;
            r_mem_req_addr   <= '0;
            r_mem_req_data   <= '0;
            r_mem_req_byteen <= '0;
            r_mem_req_tag    <= '0;
        end else if (w_slot_free) begin
            r_mem_req_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_mem_req_rw     <= w_sel_rw;
                r_mem_req_addr   <= w_sel_addr;
                r_mem_req_data   <= w_sel_data;
                r_mem_req_byteen <= w_sel_byteen;
                r_mem_req_tag    <= {w_sel_tag, w_grant_src};
            end
        end
    end

    assign bus.mem_req_valid  = r_mem_req_valid;
    assign bus.mem_req_rw     = r_mem_req_rw;
    assign bus.mem_req_addr   = r_mem_req_addr;
    assign bus.mem_req_data   = r_mem_req_data;
    assign bus.mem_req_byteen = r_mem_req_byteen;
    assign bus.mem_req_tag    = r_mem_req_tag;

    // Counts consecutive lost arbitrations of source 1; frozen while the slot is blocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (!bus.in_req_valid[1]) begin
            r_starve_cnt <= '0;
        end else if (w_slot_free) begin
            if (w_grant_vld && w_grant_src) begin
                r_starve_cnt <= '0;
            end else if (w_elig[1] && w_grant_vld && !w_grant_src
                         && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign w_rsp_src = bus.mem_rsp_tag[0];
    assign w_rsp_hs  = bus.mem_rsp_valid && bus.mem_rsp_ready;

    always_comb begin
        w_inc    = '0;
        w_dec    = '0;
        w_inc[0] = w_grant_oh[0] && !bus.in_req_rw[0];
        w_inc[1] = w_grant_oh[1] && !bus.in_req_rw[1];
        w_dec[0] = w_rsp_hs && !w_rsp_src;
        w_dec[1] = w_rsp_hs && w_rsp_src;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend[0] <= '0;
            r_pend[1] <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if (!w_inc[i] && w_dec[i] && (r_pend[i] != '0)) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
                if (w_dec[i] && (r_pend[i] == '0)) begin
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_rsp_valid = '0;
        if (w_rsp_src) begin
            bus.in_rsp_valid[1] = bus.mem_rsp_valid;
        end else begin
            bus.in_rsp_valid[0] = bus.mem_rsp_valid;
        end
    end

    assign bus.in_rsp_tag    = bus.mem_rsp_tag[TAG_WIDTH:1];
    assign bus.in_rsp_data   = bus.mem_rsp_data;
    assign bus.mem_rsp_ready = w_rsp_src ? bus.in_rsp_ready[1] : bus.in_rsp_ready[0];

    assign busy    = r_mem_req_valid || (r_pend[0] != '0) || (r_pend[1] != '0);
    assign rsp_err = r_rsp_err;
endmodule

// File: tb/tb_l1_mem_scheduler.sv
// Scoreboard bench for l1_mem_scheduler: expected memory requests are queued at grant time
// and compared by a monitor when the memory port handshakes.
module tb_l1_mem_scheduler;
    localparam int AW = 26;
    localparam int DW = 512;
    localparam int TW = 8;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic rsp_err;

    always #5 clk = ~clk;

    l1_mem_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) vif ();

    l1_mem_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .STARVE_LIMIT(4), .MAX_PENDING(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(vif.slave), .busy(busy), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [TW:0]   tag;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } req_t;

    req_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16{a[15:0], ~a[15:0]}};
    endfunction

    function automatic logic [BW-1:0] bepat(input logic [AW-1:0] a);
        return {8{a[7:0]}};
    endfunction

    task automatic set_req(input int s, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
        vif.in_req_valid[s]         = 1'b1;
        vif.in_req_rw[s]            = rw;
        vif.in_req_addr[s*AW +: AW] = a;
        vif.in_req_data[s*DW +: DW] = pat(a);
        vif.in_req_byteen[s*BW +: BW] = bepat(a);
        vif.in_req_tag[s*TW +: TW]  = t;
    endtask

    task automatic push_exp(input int s, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
        req_t e;
        e.rw   = rw;
        e.addr = a;
        e.tag  = {t, (s == 1) ? 1'b1 : 1'b0};
        e.data = pat(a);
        e.be   = bepat(a);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        vif.in_req_valid  = '0;
        vif.in_req_rw     = '0;
        vif.in_rsp_ready  = 2'b11;
        vif.mem_req_ready = 1'b1;
        vif.mem_rsp_valid = 1'b0;
        vif.mem_rsp_data  = '0;
        vif.mem_rsp_tag   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Memory-side monitor: every handshake must match the oldest expected request.
    always @(negedge clk) begin : mon
        req_t e;
        req_t got;
        if (reset && vif.mem_req_valid && vif.mem_req_ready) begin
            got = {vif.mem_req_rw, vif.mem_req_addr, vif.mem_req_tag, vif.mem_req_data, vif.mem_req_byteen};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_req_unexpected: got addr=%h tag=%h, required no request", got.addr, got.tag);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL mem_req: got rw=%b addr=%h tag=%h be=%h, required rw=%b addr=%h tag=%h be=%h",
                             got.rw, got.addr, got.tag, got.be, e.rw, e.addr, e.tag, e.be);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        exp_q.delete();
        idle();
        set_req(0, 1'b0, 26'h0000AA, 8'h01);
        set_req(1, 1'b0, 26'h0000BB, 8'h02);
        repeat (2) @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b required 00", vif.in_req_ready);
        end
        checks++;
        if (vif.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mem_valid: got %b required 0", vif.mem_req_valid);
        end
        checks++;
        if (busy !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_busy_err: got busy=%b rsp_err=%b required 0 0", busy, rsp_err);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b01) begin
            errors++; $display("FAIL reset_release_grant: got %b required 01", vif.in_req_ready);
        end
        push_exp(0, 1'b0, 26'h0000AA, 8'h01);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        checks++;
        if (vif.mem_req_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL reset_first_issue: got valid=%b busy=%b required 1 1", vif.mem_req_valid, busy);
        end
    endtask

    task automatic test_priority_starve();
        logic [1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            set_req(0, 1'b0, 26'h100 + k, 8'(k));
            set_req(1, 1'b0, 26'h200 + k, 8'(8'h80 + k));
            @(negedge clk);
            exp_rdy = ((k % 5) == 4) ? 2'b10 : 2'b01;
            checks++;
            if (vif.in_req_ready !== exp_rdy) begin
                errors++; $display("FAIL starve_grant[%0d]: got %b required %b", k, vif.in_req_ready, exp_rdy);
            end
            if (exp_rdy == 2'b10) push_exp(1, 1'b0, 26'h200 + k, 8'(8'h80 + k));
            else                  push_exp(0, 1'b0, 26'h100 + k, 8'(k));
        end
        @(posedge clk);
        #1 idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tag_routing();
        do_reset();
        @(posedge clk);
        #1 set_req(1, 1'b0, 26'h0012345, 8'h5A);
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b10) begin
            errors++; $display("FAIL tag_accept: got %b required 10", vif.in_req_ready);
        end
        push_exp(1, 1'b0, 26'h0012345, 8'h5A);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        checks++;
        if (vif.mem_req_tag !== 9'h0B5) begin
            errors++; $display("FAIL tag_out: got %h required 0b5", vif.mem_req_tag);
        end
        @(posedge clk);
        #1;
        vif.mem_rsp_valid = 1'b1;
        vif.mem_rsp_tag   = 9'h0B5;
        vif.mem_rsp_data  = pat(26'h0000C3);
        vif.in_rsp_ready  = 2'b01;
        @(negedge clk);
        checks++;
        if (vif.mem_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL rsp_ready_select: got %b required 0", vif.mem_rsp_ready);
        end
        @(posedge clk);
        #1 vif.in_rsp_ready = 2'b11;
        @(negedge clk);
        checks++;
        if (vif.in_rsp_valid !== 2'b10 || vif.in_rsp_tag !== 8'h5A || vif.mem_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_route: got valid=%b tag=%h ready=%b required 10 5a 1",
                               vif.in_rsp_valid, vif.in_rsp_tag, vif.mem_rsp_ready);
        end
        checks++;
        if (vif.in_rsp_data !== pat(26'h0000C3)) begin
            errors++; $display("FAIL rsp_data: got %h required %h", vif.in_rsp_data[31:0], pat(26'h0000C3) >> 480);
        end
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL tag_pend_drain: got busy=%b rsp_err=%b required 0 0", busy, rsp_err);
        end
    endtask

    task automatic test_pending_limit();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1 set_req(0, 1'b0, 26'h500 + k, 8'(k));
            @(negedge clk);
            checks++;
            if (vif.in_req_ready !== 2'b01) begin
                errors++; $display("FAIL pend_fill[%0d]: got %b required 01", k, vif.in_req_ready);
            end
            push_exp(0, 1'b0, 26'h500 + k, 8'(k));
        end
        @(posedge clk);
        #1 set_req(0, 1'b0, 26'h600, 8'h40);
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b00) begin
            errors++; $display("FAIL pend_full_stall: got %b required 00", vif.in_req_ready);
        end
        @(posedge clk);
        #1 set_req(0, 1'b1, 26'h610, 8'h41);
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b01) begin
            errors++; $display("FAIL pend_full_write: got %b required 01", vif.in_req_ready);
        end
        push_exp(0, 1'b1, 26'h610, 8'h41);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 26'h600, 8'h40);
        vif.mem_rsp_valid = 1'b1;
        vif.mem_rsp_tag   = {8'h00, 1'b0};
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b00) begin
            errors++; $display("FAIL pend_rsp_cycle: got %b required 00", vif.in_req_ready);
        end
        @(posedge clk);
        #1 vif.mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b01) begin
            errors++; $display("FAIL pend_release: got %b required 01", vif.in_req_ready);
        end
        push_exp(0, 1'b0, 26'h600, 8'h40);
        @(posedge clk);
        #1 idle();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL pend_busy: got %b required 1", busy);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_rdy;
        do_reset();
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 26'h300, 8'h10);
        set_req(1, 1'b0, 26'h400, 8'h20);
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_first: got %b required 01", vif.in_req_ready);
        end
        push_exp(0, 1'b0, 26'h300, 8'h10);
        @(posedge clk);
        #1;
        vif.mem_req_ready = 1'b0;
        set_req(0, 1'b0, 26'h301, 8'h11);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (vif.in_req_ready !== 2'b00 || vif.mem_req_valid !== 1'b1 || vif.mem_req_addr !== 26'h300
                || vif.mem_req_tag !== {8'h10, 1'b0} || vif.mem_req_data !== pat(26'h300)) begin
                errors++; $display("FAIL bp_hold[%0d]: got ready=%b valid=%b addr=%h tag=%h required 00 1 300 020",
                                   j, vif.in_req_ready, vif.mem_req_valid, vif.mem_req_addr, vif.mem_req_tag);
            end
            @(posedge clk);
            #1;
        end
        vif.mem_req_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                @(posedge clk);
                #1 set_req(0, 1'b0, 26'h301 + r, 8'(8'h11 + r));
            end
            @(negedge clk);
            exp_rdy = (r == 3) ? 2'b10 : 2'b01;
            checks++;
            if (vif.in_req_ready !== exp_rdy) begin
                errors++; $display("FAIL bp_starve_held[%0d]: got %b required %b", r, vif.in_req_ready, exp_rdy);
            end
            if (r == 3) push_exp(1, 1'b0, 26'h400, 8'h20);
            else        push_exp(0, 1'b0, 26'h301 + r, 8'(8'h11 + r));
        end
        @(posedge clk);
        #1 idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous_underflow();
        do_reset();
        @(posedge clk);
        #1 set_req(0, 1'b0, 26'h700, 8'h01);
        @(negedge clk);
        push_exp(0, 1'b0, 26'h700, 8'h01);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 26'h701, 8'h02);
        vif.mem_rsp_valid = 1'b1;
        vif.mem_rsp_tag   = {8'h01, 1'b0};
        @(negedge clk);
        checks++;
        if (vif.in_req_ready !== 2'b01 || vif.mem_rsp_ready !== 1'b1 || vif.in_rsp_valid !== 2'b01) begin
            errors++; $display("FAIL simul_cycle: got ready=%b rsp_ready=%b rsp_valid=%b required 01 1 01",
                               vif.in_req_ready, vif.mem_rsp_ready, vif.in_rsp_valid);
        end
        push_exp(0, 1'b0, 26'h701, 8'h02);
        @(posedge clk);
        #1;
        vif.in_req_valid = '0;
        vif.mem_rsp_tag  = {8'h02, 1'b0};
        @(posedge clk);
        #1 vif.mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL simul_pend: got busy=%b rsp_err=%b required 0 0", busy, rsp_err);
        end
        @(posedge clk);
        #1;
        vif.mem_rsp_valid = 1'b1;
        vif.mem_rsp_tag   = {8'h33, 1'b1};
        @(posedge clk);
        #1 vif.mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL underflow: got rsp_err=%b busy=%b required 1 0", rsp_err, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_err !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky: got %b required 1", rsp_err);
        end
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (rsp_err !== 1'b0 || vif.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL underflow_reset_clear: got rsp_err=%b valid=%b required 0 0", rsp_err, vif.mem_req_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        idle();
        vif.in_req_addr   = '0;
        vif.in_req_data   = '0;
        vif.in_req_byteen = '0;
        vif.in_req_tag    = '0;
        test_reset();
        test_priority_starve();
        test_tag_routing();
        test_pending_limit();
        test_backpressure();
        test_simultaneous_underflow();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d requests never issued, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
